// File: rtl/wb_arb_decode_2x2.sv
// Wishbone 2-master / 2-slave interconnect: round-robin arbitration held for the
// whole cycle, one-bit address decode, and a bus-timeout watchdog returning err.
module wb_arb_decode_2x2 #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 8,
   parameter int SEL_BIT = 15,
   parameter int TIMEOUT = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [ADDR_W-1:0] m0_adr_i,
   input  logic [DATA_W-1:0] m0_dat_i,
   output logic [DATA_W-1:0] m0_dat_o,
   input  logic              m0_we_i,
   input  logic              m0_stb_i,
   input  logic              m0_cyc_i,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   input  logic [ADDR_W-1:0] m1_adr_i,
   input  logic [DATA_W-1:0] m1_dat_i,
   output logic [DATA_W-1:0] m1_dat_o,
   input  logic              m1_we_i,
   input  logic              m1_stb_i,
   input  logic              m1_cyc_i,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   output logic [ADDR_W-1:0] s0_adr_o,
   output logic [DATA_W-1:0] s0_dat_o,
   input  logic [DATA_W-1:0] s0_dat_i,
   output logic              s0_we_o,
   output logic              s0_stb_o,
   output logic              s0_cyc_o,
   input  logic              s0_ack_i,
   output logic [ADDR_W-1:0] s1_adr_o,
   output logic [DATA_W-1:0] s1_dat_o,
   input  logic [DATA_W-1:0] s1_dat_i,
   output logic              s1_we_o,
   output logic              s1_stb_o,
   output logic              s1_cyc_o,
   input  logic              s1_ack_i,
   output logic [1:0]        gnt_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t            state, state_nxt;
   logic              last_gnt, last_gnt_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;

   logic              granted;
   logic [ADDR_W-1:0] g_adr;
   logic [DATA_W-1:0] g_dat;
   logic              g_we, g_stb, g_cyc;
   logic              sel, sel_ack, expire;
   logic [DATA_W-1:0] sel_dat;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         cnt      <= '0;
      end else begin
         state    <= state_nxt;
         last_gnt <= last_gnt_nxt;
         cnt      <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      last_gnt_nxt = last_gnt;
      granted      = 1'b0;
      g_adr        = '0;
      g_dat        = '0;
      g_we         = 1'b0;
      g_stb        = 1'b0;
      g_cyc        = 1'b0;
      cnt_nxt      = '0;

      case (state)
         IDLE: begin
            // On a tie the master that was not granted last wins.
            if (m0_cyc_i && (!m1_cyc_i || last_gnt)) begin
               state_nxt    = GNT0;
               last_gnt_nxt = 1'b0;
            end else if (m1_cyc_i) begin
               state_nxt    = GNT1;
               last_gnt_nxt = 1'b1;
            end
         end
         GNT0: begin
            granted = 1'b1;
            g_adr   = m0_adr_i;
            g_dat   = m0_dat_i;
            g_we    = m0_we_i;
            g_stb   = m0_stb_i;
            g_cyc   = m0_cyc_i;
            if (!m0_cyc_i) state_nxt = IDLE;
         end
         GNT1: begin
            granted = 1'b1;
            g_adr   = m1_adr_i;
            g_dat   = m1_dat_i;
            g_we    = m1_we_i;
            g_stb   = m1_stb_i;
            g_cyc   = m1_cyc_i;
            if (!m1_cyc_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      sel     = g_adr[SEL_BIT];
      sel_ack = sel ? s1_ack_i : s0_ack_i;
      sel_dat = sel ? s1_dat_i : s0_dat_i;
      expire  = granted && g_stb && (cnt == CNT_MAX);

      if (granted && g_stb && !sel_ack && !expire)
         cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

      // Expiry drops the slave strobe; a coincident ack still wins over err.
      s0_adr_o = g_adr;
      s1_adr_o = g_adr;
      s0_dat_o = g_dat;
      s1_dat_o = g_dat;
      s0_cyc_o = !sel && g_cyc && !expire;
      s0_stb_o = !sel && g_stb && !expire;
      s0_we_o  = !sel && g_we;
      s1_cyc_o = sel && g_cyc && !expire;
      s1_stb_o = sel && g_stb && !expire;
      s1_we_o  = sel && g_we;

      m0_ack_o = (state == GNT0) && sel_ack;
      m0_err_o = (state == GNT0) && expire && !sel_ack;
      m0_dat_o = (state == GNT0) ? sel_dat : '0;
      m1_ack_o = (state == GNT1) && sel_ack;
      m1_err_o = (state == GNT1) && expire && !sel_ack;
      m1_dat_o = (state == GNT1) ? sel_dat : '0;

      gnt_o = {state == GNT1, state == GNT0};
   end

endmodule

// File: doc/wb_arb_decode_2x2.md
Name: wb_arb_decode_2x2

Overview:
- Wishbone interconnect controller. Two bus masters (for example the Z80 core and a second CPU or DMA) share the two peripheral slaves (the I2C bridges).
- Arbitrates between the masters round-robin, with the grant held for the whole cycle (cyc).
- Decodes one address bit to pick the slave.
- Runs a bus-timeout watchdog that returns err when a slave never answers, so a hung I2C bridge cannot lock up a CPU.

Parameters:
ADDR_W, 16, address width
DATA_W, 8, data width
SEL_BIT, 15, address bit used for slave select: 0 selects s0, 1 selects s1
TIMEOUT, 255, max cycles a strobe may wait for ack before err; must be >= 2

Ports:
wb_clk_i  in  1  single system clock; all logic is on its rising edge
wb_rst_i  in  1  synchronous, active-high reset
m0_adr_i  in  ADDR_W  master 0 address
m0_dat_i  in  DATA_W  master 0 write data
m0_dat_o  out  DATA_W  read data to master 0
m0_we_i  in  1  master 0 write enable
m0_stb_i  in  1  master 0 strobe
m0_cyc_i  in  1  master 0 cycle
m0_ack_o  out  1  ack to master 0
m0_err_o  out  1  timeout error to master 0
m1_*  -  -  same set as m0_*, for master 1
s0_adr_o  out  ADDR_W  slave 0 address (full address passed through)
s0_dat_o  out  DATA_W  write data to slave 0
s0_dat_i  in  DATA_W  slave 0 read data
s0_we_o  out  1  slave 0 write enable
s0_stb_o  out  1  slave 0 strobe
s0_cyc_o  out  1  slave 0 cycle
s0_ack_i  in  1  slave 0 ack
s1_*  -  -  same set as s0_*, for slave 1
gnt_o  out  2  one-hot current grant, for debug

Behaviour:
- States:
  - IDLE: no grant.
  - GNT0: master 0 owns the bus.
  - GNT1: master 1 owns the bus.
  - Register last_gnt tracks which master was granted most recently.
- Reset (wb_rst_i=1 at an edge):
  - state=IDLE, last_gnt=1, timeout counter=0.
  - All s*_stb_o/cyc_o/we_o=0.
  - All m*_ack_o/err_o=0, m*_dat_o=0, gnt_o=0.
  - Reset in mid-transfer aborts the transfer; no ack or err is issued for it.
- IDLE transitions:
  - Only m0_cyc_i=1 -> GNT0. Only m1_cyc_i=1 -> GNT1.
  - Both -> grant the master != last_gnt, so m0 wins the first contest after reset.
  - last_gnt is updated on entry to a grant state.
- GNTx:
  - Stays in GNTx while mx_cyc_i=1, so block transfers are not interleaved.
  - mx_cyc_i=0 at an edge -> IDLE. This costs one dead cycle before any new grant (re-arbitration is always via IDLE).
- Latency:
  - A request is first seen by the slave on the cycle after the master raises cyc in IDLE.
  - In GNTx, forwarding is combinational: stb/we/adr/dat to the slave, ack/dat back to the master.
- Decode, in GNTx:
  - Slave sel = mx_adr_i[SEL_BIT].
  - The selected slave gets cyc=mx_cyc_i, stb=mx_stb_i, we=mx_we_i, adr, dat.
  - The unselected slave gets cyc/stb/we=0. Both slaves receive adr/dat of the granted master.
  - mx_ack_o = ack of the selected slave. mx_dat_o = dat_i of the selected slave.
  - The non-granted master sees ack=0, err=0, dat=0.
- Timeout:
  - Counter increments each cycle that the granted stb=1 and the selected ack=0.
  - Counter clears when ack=1, when stb=0, or in IDLE.
  - When the counter reaches TIMEOUT-1 with ack still 0, the next cycle:
    - asserts mx_err_o=1 for exactly one cycle;
    - forces the selected slave's stb/cyc to 0 in that cycle;
    - clears the counter.
  - If the master keeps stb=1 afterwards, the count restarts.
  - An ack arriving in the same cycle as the expiry takes precedence: ack is passed, no err.
- Counter width: ceil(log2(TIMEOUT+1)), saturating; no wrap.
- ack and err are never both 1.
- gnt_o = {state==GNT1, state==GNT0}.

Test Plan:
- Reset, then m0 writes adr=0x8005, dat=0x5A, s1 acks after 2 cycles -> s1 sees stb one cycle after cyc, we=1, dat=0x5A; s0 stays idle; m0_ack_o pulses once; gnt_o=01.
- m1 reads adr=0x0010, s0 returns 0xC3 with ack -> m1_dat_o=0xC3 in the ack cycle; s1 stb stays 0.
- m0 and m1 raise cyc in the same cycle right after reset -> m0 is granted first. After m0 drops cyc: one IDLE cycle, then m1 is granted. Next simultaneous contest goes to m0.
- m0 holds cyc across 3 strobes while m1 requests -> m1 is not granted until m0 cyc=0; m1 ack=0 throughout.
- m0 strobe to s0 which never acks, TIMEOUT=8 -> m0_err_o=1 for one cycle after 8 waiting cycles; s0_stb_o=0 in that cycle; ack never asserted.
- wb_rst_i=1 mid-transfer while GNT1 is active -> next cycle state=IDLE, all strobes/acks 0; after reset, a simultaneous request grants m0.
